// File: rtl/wb_slave_resp_pkg.sv
// Shared definitions for the Wishbone responder: FSM encoding, SPI register offsets
// and the byte-lane merge used by the register file.
package wb_slave_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [4:0] OFS_RX_0   = 5'h00;
    localparam logic [4:0] OFS_TX_0   = 5'h00;
    localparam logic [4:0] OFS_RX_1   = 5'h04;
    localparam logic [4:0] OFS_RX_2   = 5'h08;
    localparam logic [4:0] OFS_RX_3   = 5'h0C;
    localparam logic [4:0] OFS_CTRL   = 5'h10;
    localparam logic [4:0] OFS_DIVIDE = 5'h14;
    localparam logic [4:0] OFS_SS     = 5'h18;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < 4; k++)
            if (sel[k]) res[k*8 +: 8] = new_w[k*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/wb_slave_regfile.sv
// DEPTH x 32 word storage with per-byte write enables and combinational read.
// Indices at or beyond DEPTH read as zero and are never written.
module wb_slave_regfile
    import wb_slave_resp_pkg::*;
#(
    parameter int DEPTH = 7,
    parameter int IW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [3:0]    sel,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                mem[w] <= '0;
            else if (we && idx == IW'(w))
                mem[w] <= byte_merge(mem[w], wdata, sel);
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++)
            if (idx == IW'(i)) rdata = mem[i];
    end

endmodule

// File: rtl/wb_slave_resp.sv
// Wishbone classic-cycle target: small register file, programmable wait states,
// error termination for out-of-range words, and a completed-access counter.
module wb_slave_resp
    import wb_slave_resp_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 7
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    input  logic [3:0]    wait_cfg_i,
    output logic [15:0]   acc_cnt_o
);

    localparam int IW = AW - 2;
    localparam logic [IW:0] DEPTH_W = DEPTH[IW:0];

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [DW-1:0] dat_q;
    logic          err_q;
    logic [3:0]    cnt_q;
    logic [15:0]   acc_q;
    logic [31:0]   rdata;

    logic          req, oor, resp;
    logic [IW-1:0] idx_in;
    logic          unused_adr_lsb;

    assign req            = wb_cyc_i & wb_stb_i;
    assign idx_in         = wb_adr_i[AW-1:2];
    assign oor            = {1'b0, idx_in} >= DEPTH_W;
    assign unused_adr_lsb = ^wb_adr_i[1:0];

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                idx_q <= idx_in;
                we_q  <= wb_we_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
                err_q <= oor;
                cnt_q <= wait_cfg_i;
            end else if (state_q == WAIT) begin
                cnt_q <= req ? cnt_q - 4'd1 : '0;
            end
            // Counter wraps naturally at 16 bits; aborts never reach RESP.
            if (state_q == RESP)
                acc_q <= acc_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req) state_d = (wait_cfg_i != '0) ? WAIT : RESP;
            WAIT: begin
                if (!req)              state_d = IDLE;
                else if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Terminations decode straight from the state flop, so each lasts exactly one cycle.
    assign resp      = (state_q == RESP);
    assign wb_ack_o  = resp & ~err_q;
    assign wb_err_o  = resp & err_q;
    assign wb_dat_o  = wb_ack_o ? rdata : '0;
    assign acc_cnt_o = acc_q;

    wb_slave_regfile #(.DEPTH(DEPTH), .IW(IW)) u_regfile (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .we    (resp & we_q & ~err_q),
        .sel   (sel_q),
        .idx   (idx_q),
        .wdata (dat_q),
        .rdata (rdata)
    );

endmodule
